// File: rtl/alu_arbiter_pkg.sv
// Shared widths, ALU opcodes and arbiter FSM encoding for the shared-ALU arbiter.
package alu_arbiter_pkg;

    localparam int ALU_WIDTH = 12;
    localparam int ALU_OPW   = 3;

    localparam logic [ALU_OPW-1:0] OP_SHR = 3'd0;
    localparam logic [ALU_OPW-1:0] OP_SHL = 3'd1;
    localparam logic [ALU_OPW-1:0] OP_AND = 3'd2;
    localparam logic [ALU_OPW-1:0] OP_OR  = 3'd3;
    localparam logic [ALU_OPW-1:0] OP_XOR = 3'd4;
    localparam logic [ALU_OPW-1:0] OP_NOT = 3'd5;
    localparam logic [ALU_OPW-1:0] OP_ADD = 3'd6;
    localparam logic [ALU_OPW-1:0] OP_SUB = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu.sv
// Combinational 12-bit ALU: shifts by one, bitwise ops, add and subtract with flags.
// No state, no handshake; outputs follow inputs in the same cycle.
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [ALU_OPW-1:0] op_select,
    output logic [WIDTH-1:0]   out,
    output logic               zero,
    output logic               cout,
    output logic               sign,
    output logic               overflow
);

    always_comb begin
        out      = '0;
        cout     = 1'b0;
        overflow = 1'b0;
        case (op_select)
            OP_SHR: begin
                out  = a >> 1;
                cout = a[0];
            end
            OP_SHL: begin
                out  = a << 1;
                cout = a[WIDTH-1];
            end
            OP_AND: out = a & b;
            OP_OR:  out = a | b;
            OP_XOR: out = a ^ b;
            OP_NOT: out = ~a;
            OP_ADD: begin
                {cout, out} = {1'b0, a} + {1'b0, b};
                overflow    = (a[WIDTH-1] == b[WIDTH-1]) && (out[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // cout is the no-borrow carry of a + ~b + 1
                {cout, out} = {1'b0, a} + {1'b0, ~b} + 1'b1;
                overflow    = (a[WIDTH-1] != b[WIDTH-1]) && (out[WIDTH-1] != a[WIDTH-1]);
            end
            default: ;
        endcase
    end

    assign zero = (out == '0);
    assign sign = out[WIDTH-1];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two requesters; response two edges after accept.
// Readies are low outside IDLE; the response is held until rsp_ready, blocking new accepts.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_cout,
    output logic             rsp_sign,
    output logic             rsp_ovf,
    output logic             busy,
    output logic [CNTW-1:0]  done_count
);

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [OPW-1:0]   op_sel;
    logic             op_id;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero_unused;
    logic             alu_cout;
    logic             alu_sign;
    logic             alu_ovf;

    // Requester 0 wins a tie unless it was the last one served.
    assign grant0     = req0_valid & (~req1_valid | last_grant);
    assign grant1     = req1_valid & ~grant0;
    assign req0_ready = (state == ST_IDLE) & grant0;
    assign req1_ready = (state == ST_IDLE) & grant1;
    assign accept     = req0_ready | req1_ready;
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            op_sel     <= '0;
            op_id      <= 1'b0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_cout   <= 1'b0;
            rsp_sign   <= 1'b0;
            rsp_ovf    <= 1'b0;
            done_count <= '0;
        end else begin
            if (accept) begin
                op_a       <= grant1 ? req1_a  : req0_a;
                op_b       <= grant1 ? req1_b  : req0_b;
                op_sel     <= grant1 ? req1_op : req0_op;
                op_id      <= grant1;
                last_grant <= grant1;
            end
            if (state == ST_EXEC) begin
                rsp_valid <= 1'b1;
                rsp_id    <= op_id;
                rsp_data  <= alu_out;
                rsp_cout  <= alu_cout;
                rsp_sign  <= alu_sign;
                rsp_ovf   <= alu_ovf;
            end
            if ((state == ST_RESP) && rsp_ready) begin
                rsp_valid  <= 1'b0;
                done_count <= done_count + 1'b1;
            end
        end
    end

    alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .a        (op_a),
        .b        (op_b),
        .op_select(op_sel),
        .out      (alu_out),
        .zero     (alu_zero_unused),
        .cout     (alu_cout),
        .sign     (alu_sign),
        .overflow (alu_ovf)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, random ops vs. model, handshake corner cases.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    typedef struct packed {
        logic [11:0] data;
        logic        cout;
        logic        sign;
        logic        ovf;
    } rsp_t;

    typedef struct {
        logic        id;
        logic [11:0] a;
        logic [11:0] b;
        logic [2:0]  op;
        rsp_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [11:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic        rsp_valid, rsp_id, rsp_cout, rsp_sign, rsp_ovf, busy;
    logic        rsp_ready = 1'b0;
    logic [11:0] rsp_data;
    logic [7:0]  done_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_done = 0;
    logic        got_id [8];
    logic [11:0] got_dat [8];

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_cout(rsp_cout), .rsp_sign(rsp_sign),
        .rsp_ovf(rsp_ovf), .busy(busy), .done_count(done_count)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference ALU from two's-complement arithmetic on plain integers.
    function automatic rsp_t model(input logic [11:0] a, input logic [11:0] b, input logic [2:0] op);
        int ia, ib, sa, sb, r, s;
        rsp_t e;
        ia = int'(a);
        ib = int'(b);
        sa = (ia >= 2048) ? ia - 4096 : ia;
        sb = (ib >= 2048) ? ib - 4096 : ib;
        r = 0;
        e.cout = 1'b0;
        e.ovf  = 1'b0;
        case (op)
            3'd0: begin r = ia / 2; e.cout = (ia % 2) == 1; end
            3'd1: begin r = (ia * 2) % 4096; e.cout = ia >= 2048; end
            3'd2: r = ia & ib;
            3'd3: r = ia | ib;
            3'd4: r = ia ^ ib;
            3'd5: r = 4095 - ia;
            3'd6: begin
                r = (ia + ib) % 4096;
                e.cout = (ia + ib) >= 4096;
                s = sa + sb;
                e.ovf = (s > 2047) || (s < -2048);
            end
            default: begin
                r = (ia - ib + 4096) % 4096;
                e.cout = ia >= ib;
                s = sa - sb;
                e.ovf = (s > 2047) || (s < -2048);
            end
        endcase
        e.data = r[11:0];
        e.sign = r >= 2048;
        return e;
    endfunction

    function automatic vec_t mk(input logic id, input logic [11:0] a, input logic [11:0] b,
                                input logic [2:0] op, input logic [11:0] d,
                                input logic c, input logic s, input logic v);
        vec_t t;
        t.id = id; t.a = a; t.b = b; t.op = op;
        t.exp.data = d; t.exp.cout = c; t.exp.sign = s; t.exp.ovf = v;
        return t;
    endfunction

    task automatic drive(input logic id, input logic v, input logic [11:0] a,
                         input logic [11:0] b, input logic [2:0] op);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    // Waits (bounded) until the given requester sees ready; returns 0 on timeout.
    task automatic wait_ready(input logic id, output bit ok);
        int waitc;
        waitc = 0;
        #1;
        while (!(id ? req1_ready : req0_ready) && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        ok = (waitc < 20);
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: requester %0d never got ready", id);
        end
    endtask

    task automatic run_one(input logic id, input logic [11:0] a, input logic [11:0] b,
                           input logic [2:0] op, input rsp_t e, input int hold);
        bit ok;
        drive(id, 1'b1, a, b, op);
        wait_ready(id, ok);
        if (!ok) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        check("single_ready", req0_ready & req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check("exec_rsp_valid", rsp_valid, 0);
        check("exec_busy", busy, 1);
        check("exec_readies", {req0_ready, req1_ready}, 0);
        @(negedge clk);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, id);
        check("rsp_data", rsp_data, e.data);
        check("rsp_flags", {rsp_cout, rsp_sign, rsp_ovf}, {e.cout, e.sign, e.ovf});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_data", {rsp_valid, rsp_data}, {1'b1, e.data});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_done++;
        @(negedge clk);
        check("done_count", done_count, exp_done % 256);
        check("idle_after_rsp", {busy, rsp_valid}, 0);
    endtask

    // Both requesters held valid with rsp_ready=1; collects nrsp responses.
    task automatic contend(input int nrsp,
                           input logic [11:0] a0, input logic [11:0] b0, input logic [2:0] op0,
                           input logic [11:0] a1, input logic [11:0] b1, input logic [2:0] op1);
        int cyc, got, last_acc;
        cyc = 0; got = 0; last_acc = -1;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, a0, b0, op0);
        drive(1'b1, 1'b1, a1, b1, op1);
        rsp_ready = 1'b1;
        while (got < nrsp && cyc < 100) begin
            @(negedge clk);
            cyc++;
            check("one_ready", req0_ready & req1_ready, 0);
            if (req0_ready || req1_ready) begin
                if (last_acc >= 0) check("accept_spacing", cyc - last_acc, 3);
                last_acc = cyc;
            end
            if (rsp_valid) begin
                got_id[got]  = rsp_id;
                got_dat[got] = rsp_data;
                got++;
                exp_done++;
            end
        end
        if (got < nrsp) begin
            n_checks++;
            n_errors++;
            $display("FAIL contend_timeout: %0d of %0d responses", got, nrsp);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_done = 0;
    endtask

    vec_t        tbl [12];
    logic        rid;
    logic [11:0] ra, rb;
    logic [2:0]  rop;
    rsp_t        e;
    bit          ok;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(1'b0, 12'h801, 12'h861, OP_ADD, 12'h062, 1, 0, 1);
        tbl[1]  = mk(1'b1, 12'hEF1, 12'hE65, OP_AND, 12'hE61, 0, 1, 0);
        tbl[2]  = mk(1'b0, 12'hEF1, 12'hE65, OP_XOR, 12'h094, 0, 0, 0);
        tbl[3]  = mk(1'b1, 12'h60F, 12'h061, OP_ADD, 12'h670, 0, 0, 0);
        tbl[4]  = mk(1'b0, 12'h005, 12'h007, OP_SUB, 12'hFFE, 0, 1, 0);
        tbl[5]  = mk(1'b1, 12'h800, 12'h001, OP_SUB, 12'h7FF, 1, 0, 1);
        tbl[6]  = mk(1'b0, 12'h803, 12'h000, OP_SHR, 12'h401, 1, 0, 0);
        tbl[7]  = mk(1'b1, 12'h801, 12'h000, OP_SHL, 12'h002, 1, 0, 0);
        tbl[8]  = mk(1'b0, 12'h0F0, 12'h00F, OP_OR,  12'h0FF, 0, 0, 0);
        tbl[9]  = mk(1'b1, 12'h0F0, 12'hABC, OP_NOT, 12'hF0F, 0, 1, 0);
        tbl[10] = mk(1'b0, 12'h7FF, 12'h001, OP_ADD, 12'h800, 0, 1, 1);
        tbl[11] = mk(1'b1, 12'h123, 12'h123, OP_SUB, 12'h000, 1, 0, 0);

        repeat (2) @(negedge clk);
        check("reset_outputs", {rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_sign, rsp_ovf, busy}, 0);
        check("reset_done_count", done_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_valid_readies", {req0_ready, req1_ready, busy}, 0);

        for (int i = 0; i < 12; i++)
            run_one(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp, i % 3);

        // Enough random ops to wrap done_count.
        for (int i = 0; i < 260; i++) begin
            rid = 1'($urandom_range(0, 1));
            ra  = 12'($urandom_range(0, 4095));
            rb  = 12'($urandom_range(0, 4095));
            rop = 3'($urandom_range(0, 7));
            run_one(rid, ra, rb, rop, model(ra, rb, rop), int'($urandom_range(0, 2)));
        end

        // Reset asserted mid-cycle while a response is pending.
        drive(1'b1, 1'b1, 12'h7FF, 12'h001, OP_ADD);
        wait_ready(1'b1, ok);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b1, 12'h800});
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_rsp", {rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_sign, rsp_ovf}, 0);
        check("async_reset_busy_cnt", {busy, done_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_done = 0;

        // Simultaneous requests straight after reset: requester 0 first.
        contend(2, 12'hEF1, 12'hE65, OP_AND, 12'hEF1, 12'hE65, OP_XOR);
        check("sim_first_id", got_id[0], 0);
        check("sim_first_data", got_dat[0], 12'hE61);
        check("sim_second_id", got_id[1], 1);
        check("sim_second_data", got_dat[1], 12'h094);
        @(negedge clk);
        check("sim_done_count", done_count, 2);

        // Fairness: strict alternation with both requesters always valid.
        pulse_reset();
        ra = 12'($urandom_range(0, 4095));
        rb = 12'($urandom_range(0, 4095));
        contend(4, ra, rb, OP_ADD, rb, ra, OP_SUB);
        for (int k = 0; k < 4; k++) begin
            check("fair_id", got_id[k], k % 2);
            e = (k % 2 == 0) ? model(ra, rb, OP_ADD) : model(rb, ra, OP_SUB);
            check("fair_data", got_dat[k], e.data);
        end
        @(negedge clk);
        check("fair_done_count", done_count, 4);

        // Backpressure: response held, competing requester waits.
        drive(1'b0, 1'b1, 12'h60F, 12'h061, OP_ADD);
        wait_ready(1'b0, ok);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        drive(1'b1, 1'b1, 12'h123, 12'h045, OP_SUB);
        @(negedge clk);
        check("bp_exec_ready1", req1_ready, 0);
        @(negedge clk);
        check("bp_rsp", {rsp_valid, rsp_data, rsp_ovf}, {1'b1, 12'h670, 1'b0});
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            check("bp_hold", {rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_sign, rsp_ovf},
                  {1'b1, 1'b0, 12'h670, 1'b0, 1'b0, 1'b0});
            check("bp_ready1_low", req1_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_ready1_after", req1_ready, 1);
        check("bp_done_count", done_count, 5);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        e = model(12'h123, 12'h045, OP_SUB);
        check("bp_req1_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b1, e.data});
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset during EXEC discards the operation.
        drive(1'b0, 1'b1, 12'h801, 12'h861, OP_ADD);
        wait_ready(1'b0, ok);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        check("exec_busy_before_reset", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("exec_reset_clears", {busy, rsp_valid, done_count, rsp_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_rsp_after_reset", {rsp_valid, busy, done_count}, 0);
        end
        drive(1'b0, 1'b1, 12'h001, 12'h002, OP_ADD);
        drive(1'b1, 1'b1, 12'h003, 12'h004, OP_ADD);
        #1;
        check("post_reset_grant", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
